// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the EX stage.
// Operands are captured once as magnitudes plus sign bits; the multiply core is
// given MUL_LAT cycles, the divider is restoring radix-2 (one quotient bit per
// cycle). Sign correction is applied in FIX and the {hi, lo, dz} result
// registers only change on the FIX -> DONE transition.
module muldiv_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    // Counter must reach the longer of the two phases.
    localparam int unsigned CntMax = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] MulLast = CntW'(MUL_LAT - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(WIDTH - 1);

    localparam logic [1:0] OpMul = 2'b01;
    localparam logic [1:0] OpDiv = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDiv,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0]    cnt_q, cnt_d;

    // Captured operand magnitudes and sign bits.
    logic [WIDTH-1:0]   a_abs_q, b_abs_q;
    logic               a_neg_q, b_neg_q;
    logic               is_div_q;

    // Working pair: product {rem, quo} for multiply, remainder/quotient for divide.
    logic [WIDTH-1:0]   rem_q, quo_q;

    // Architectural result registers.
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               dz_q;

    // Request decode.
    logic               op_mul, op_div, op_valid, accept;
    logic               in_start_state;

    // Operand conditioning.
    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_abs_in, b_abs_in;

    // Datapath intermediates.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;

    // Sign-correction intermediates.
    logic               res_neg;
    logic [2*WIDTH-1:0] mul_mag, mul_res;
    logic [WIDTH-1:0]   quo_signed, rem_signed, a_orig;
    logic               div_zero;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               fix_dz;
    logic               load_result;

    // Decode the request and condition the operands.
    always_comb begin
        op_mul         = (op == OpMul);
        op_div         = (op == OpDiv);
        op_valid       = op_mul | op_div;
        in_start_state = (state_q == StIdle) || (state_q == StDone);
        accept         = in_start_state && start && op_valid && !annul;

        a_neg_in = sign & a[WIDTH-1];
        b_neg_in = sign & b[WIDTH-1];
        a_abs_in = a_neg_in ? (~a + 1'b1) : a;
        b_abs_in = b_neg_in ? (~b + 1'b1) : b;
    end

    // Next-state and counter logic; annul overrides every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = op_mul ? StMul : StDiv;
                end else begin
                    state_d = StIdle;
                end
            end
            StMul: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MulLast) begin
                    state_d = StFix;
                end
            end
            StDiv: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DivLast) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (annul) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiply core and one restoring divide step.
    always_comb begin
        prod = {{WIDTH{1'b0}}, a_abs_q} * {{WIDTH{1'b0}}, b_abs_q};

        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_abs_q};
        // No borrow means the shifted remainder covers the divisor.
        div_fits  = !div_diff[WIDTH];

        if (div_fits) begin
            div_rem_nxt = div_diff[WIDTH-1:0];
            div_quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nxt = div_shift[WIDTH-1:0];
            div_quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand capture and working registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            is_div_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
        end else if (accept) begin
            a_abs_q  <= a_abs_in;
            b_abs_q  <= b_abs_in;
            a_neg_q  <= a_neg_in;
            b_neg_q  <= b_neg_in;
            is_div_q <= op_div;
            rem_q    <= '0;
            quo_q    <= a_abs_in;
        end else if (state_q == StMul) begin
            // Reloaded every MUL cycle so the multiplier can be retimed across the phase.
            {rem_q, quo_q} <= prod;
        end else if (state_q == StDiv) begin
            rem_q <= div_rem_nxt;
            quo_q <= div_quo_nxt;
        end
    end

    // Sign correction and result selection for the FIX state.
    always_comb begin
        res_neg    = a_neg_q ^ b_neg_q;
        mul_mag    = {rem_q, quo_q};
        mul_res    = res_neg ? (~mul_mag + 1'b1) : mul_mag;
        quo_signed = res_neg ? (~quo_q + 1'b1) : quo_q;
        rem_signed = a_neg_q ? (~rem_q + 1'b1) : rem_q;
        a_orig     = a_neg_q ? (~a_abs_q + 1'b1) : a_abs_q;
        div_zero   = (b_abs_q == '0);

        fix_hi = mul_res[2*WIDTH-1:WIDTH];
        fix_lo = mul_res[WIDTH-1:0];
        fix_dz = 1'b0;

        if (is_div_q) begin
            if (div_zero) begin
                fix_hi = a_orig;
                fix_lo = '1;
                fix_dz = 1'b1;
            end else begin
                fix_hi = rem_signed;
                fix_lo = quo_signed;
            end
        end

        load_result = (state_q == StFix) && !annul;
    end

    // Result registers; they move only when FIX completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else if (load_result) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
            dz_q <= fix_dz;
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy  = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
        ready = (state_q == StDone);
        hi    = hi_q;
        lo    = lo_q;
        dz    = dz_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results are queued when an
// operation is issued and compared by a monitor when ready pulses.
module tb_muldiv_unit;

    localparam int unsigned W       = 32;
    localparam int unsigned ML      = 4;
    localparam int          MUL_RDY = ML + 2;
    localparam int          DIV_RDY = W + 2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        sign;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    exp_t m;

    muldiv_unit #(
        .WIDTH   (W),
        .MUL_LAT (ML)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .sign  (sign),
        .annul (annul),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .ready (ready),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model built on native 64-bit arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic s,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        r;
        longint      sx, sy, sp;
        logic [63:0] up;
        r.dz = 1'b0;
        if (o == 2'b01) begin
            if (s) begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                sp = sx * sy;
                up = sp;
            end else begin
                up = {32'd0, x} * {32'd0, y};
            end
            r.hi = up[63:32];
            r.lo = up[31:0];
        end else if (y == 32'd0) begin
            r.hi = x;
            r.lo = 32'hFFFF_FFFF;
            r.dz = 1'b1;
        end else if (s) begin
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            sp   = sx / sy;
            r.lo = sp[31:0];
            sp   = sx % sy;
            r.hi = sp[31:0];
        end else begin
            r.lo = x / y;
            r.hi = x % y;
        end
        return r;
    endfunction

    // Monitor: each ready pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ready: observed ready=1 expected no pending result");
            end else begin
                mon_e = sb.pop_front();
                check("result_hi", 64'(hi), 64'(mon_e.hi));
                check("result_lo", 64'(lo), 64'(mon_e.lo));
                check("result_dz", 64'(dz), 64'(mon_e.dz));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic push, input exp_t e);
        start = 1'b1;
        op    = o;
        sign  = s;
        a     = x;
        b     = y;
        if (push) begin
            sb.push_back(e);
            last = e;
        end
    endtask

    // Walk from the accepting edge to the ready edge, checking busy each cycle.
    // A nonzero poke_at drives a (to-be-ignored) multiply start after that edge.
    task automatic wait_done(input int lat, input string tag, input int poke_at);
        step();
        start = 1'b0;
        for (int e = 1; e < lat; e++) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            check({tag, "_noready"}, 64'(ready), 64'd0);
            if (e == poke_at) begin
                start = 1'b1;
                op    = 2'b01;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic idle_step(input string tag);
        step();
        check({tag, "_idle_ready"}, 64'(ready), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        sign  = 1'b0;
        annul = 1'b0;
        a     = '0;
        b     = '0;
        last  = '0;
        #1 rst = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_dz", 64'(dz), 64'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // Unsigned divide with exact latency.
        issue(2'b10, 1'b0, 32'd100, 32'd7, 1'b1, '{hi: 32'd2, lo: 32'd14, dz: 1'b0});
        wait_done(DIV_RDY, "udiv", 0);
        idle_step("udiv");

        // Signed divides: truncation toward zero and MIN / -1 wrap.
        issue(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1,
              '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dz: 1'b0});
        wait_done(DIV_RDY, "sdiv", 0);
        idle_step("sdiv");
        issue(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              '{hi: 32'd0, lo: 32'h8000_0000, dz: 1'b0});
        wait_done(DIV_RDY, "sdiv_min", 0);
        idle_step("sdiv_min");

        // Multiplies, signed and unsigned.
        issue(2'b01, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1,
              '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE, dz: 1'b0});
        wait_done(MUL_RDY, "smul", 0);
        idle_step("smul");
        issue(2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1,
              '{hi: 32'd1, lo: 32'hFFFF_FFFE, dz: 1'b0});
        wait_done(MUL_RDY, "umul", 0);
        idle_step("umul");

        // Divide by zero, both signednesses, then a multiply clears dz.
        issue(2'b10, 1'b0, 32'd5, 32'd0, 1'b1, '{hi: 32'd5, lo: 32'hFFFF_FFFF, dz: 1'b1});
        wait_done(DIV_RDY, "udz", 0);
        idle_step("udz");
        check("dz_hold", 64'(dz), 64'd1);
        issue(2'b10, 1'b1, 32'd5, 32'd0, 1'b1, '{hi: 32'd5, lo: 32'hFFFF_FFFF, dz: 1'b1});
        wait_done(DIV_RDY, "sdz", 0);
        idle_step("sdz");
        issue(2'b01, 1'b0, 32'd3, 32'd4, 1'b1, '{hi: 32'd0, lo: 32'd12, dz: 1'b0});
        wait_done(MUL_RDY, "dz_clear", 0);
        idle_step("dz_clear");

        // Invalid opcodes and start with annul are ignored.
        issue(2'b00, 1'b0, 32'd9, 32'd9, 1'b0, '0);
        step();
        start = 1'b0;
        check("op00_busy", 64'(busy), 64'd0);
        issue(2'b11, 1'b0, 32'd9, 32'd9, 1'b0, '0);
        step();
        start = 1'b0;
        check("op11_busy", 64'(busy), 64'd0);
        issue(2'b01, 1'b0, 32'd9, 32'd9, 1'b0, '0);
        annul = 1'b1;
        step();
        start = 1'b0;
        annul = 1'b0;
        check("annul_start_busy", 64'(busy), 64'd0);
        check("annul_start_lo", 64'(lo), 64'(last.lo));
        step();
        step();

        // Start while busy is ignored; divide result and timing are unaffected.
        issue(2'b10, 1'b0, 32'd1000, 32'd10, 1'b1, '{hi: 32'd0, lo: 32'd100, dz: 1'b0});
        wait_done(DIV_RDY, "busy_start", 3);
        idle_step("busy_start");

        // Annul mid-divide: no ready, outputs hold, next start accepted.
        issue(2'b10, 1'b0, 32'd7777, 32'd3, 1'b0, '0);
        step();
        start = 1'b0;
        for (int e = 2; e <= 10; e++) step();
        check("pre_annul_busy", 64'(busy), 64'd1);
        annul = 1'b1;
        step();
        annul = 1'b0;
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_hi", 64'(hi), 64'(last.hi));
        check("annul_lo", 64'(lo), 64'(last.lo));
        check("annul_dz", 64'(dz), 64'(last.dz));
        step();
        issue(2'b01, 1'b0, 32'd6, 32'd7, 1'b1, '{hi: 32'd0, lo: 32'd42, dz: 1'b0});
        wait_done(MUL_RDY, "after_annul", 0);
        idle_step("after_annul");

        // Back-to-back: second start accepted during DONE.
        issue(2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1,
              '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1, dz: 1'b0});
        wait_done(MUL_RDY, "b2b_first", 0);
        issue(2'b10, 1'b0, 32'd50, 32'd8, 1'b1, '{hi: 32'd2, lo: 32'd6, dz: 1'b0});
        wait_done(DIV_RDY, "b2b_second", 0);
        idle_step("b2b");

        // Randomised operations against the reference model.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  o;
            logic        s;
            logic [31:0] x, y;
            o = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            s = 1'($urandom_range(0, 1));
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            m = model(o, s, x, y);
            issue(o, s, x, y, 1'b1, m);
            wait_done((o == 2'b01) ? MUL_RDY : DIV_RDY, "rand", 0);
            idle_step("rand");
        end

        // Reset mid-divide clears everything at once and discards the operation.
        issue(2'b10, 1'b0, 32'd123456, 32'd7, 1'b0, '0);
        for (int e = 0; e < 5; e++) step();
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_dz", 64'(dz), 64'd0);
        step();
        rst = 1'b1;
        for (int e = 0; e < 40; e++) step();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_lo", 64'(lo), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
